// File: rtl/regfile_scoreboard.sv
// Architectural register file with two bypassed read ports and a per-register
// pending-write scoreboard used by issue for RAW-hazard stalls.
module regfile_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 3,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_wb_idx,
  input  logic             i_wb_we,
  input  logic [31:0]      i_wb_data,
  input  logic [IDX_W-1:0] i_rd_idx0,
  output logic [31:0]      o_rd_data0,
  input  logic [IDX_W-1:0] i_rd_idx1,
  output logic [31:0]      o_rd_data1,
  output logic             o_busy0,
  output logic             o_busy1,
  input  logic             i_issue_valid,
  input  logic             i_issue_we,
  input  logic [IDX_W-1:0] i_issue_rd,
  output logic             o_issue_ready,
  input  logic             i_flush,
  output logic             o_sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]                 r_rf [NREG];
  logic [NREG-1:0][CNT_W-1:0]  r_cnt;
  logic                        r_sb_err;

  logic [NREG-1:0][CNT_W-1:0]  w_cnt_next;
  logic [NREG-1:0]             w_inc_hit;
  logic [NREG-1:0]             w_dec_hit;
  logic                        w_inc;
  logic                        w_dec;
  logic                        w_err;
  logic [CNT_W-1:0]            w_cnt_rd0;
  logic [CNT_W-1:0]            w_cnt_rd1;
  logic [CNT_W-1:0]            w_cnt_iss;
  logic [CNT_W-1:0]            w_cnt_wb;

  assign w_dec = i_wb_we && (i_wb_idx != '0);
  assign w_inc = i_issue_valid && i_issue_we && (i_issue_rd != '0) && o_issue_ready && !i_flush;

  assign w_cnt_rd0 = r_cnt[i_rd_idx0];
  assign w_cnt_rd1 = r_cnt[i_rd_idx1];
  assign w_cnt_iss = r_cnt[i_issue_rd];
  assign w_cnt_wb  = r_cnt[i_wb_idx];

  // Register file: r0 never written, so its storage stays at its reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) r_rf[k] <= '0;
    end else if (w_dec) begin
      r_rf[i_wb_idx] <= i_wb_data;
    end
  end

  // Read ports: r0 forced to zero, same-cycle writeback forwarded.
  always_comb begin
    o_rd_data0 = r_rf[i_rd_idx0];
    if (i_rd_idx0 == '0)                       o_rd_data0 = '0;
    else if (w_dec && (i_wb_idx == i_rd_idx0)) o_rd_data0 = i_wb_data;
  end

  always_comb begin
    o_rd_data1 = r_rf[i_rd_idx1];
    if (i_rd_idx1 == '0)                       o_rd_data1 = '0;
    else if (w_dec && (i_wb_idx == i_rd_idx1)) o_rd_data1 = i_wb_data;
  end

  // Per-register counter next-state; simultaneous inc/dec cancel out.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
      assign w_inc_hit[gi] = w_inc && (i_issue_rd == IDX_W'(gi));
      assign w_dec_hit[gi] = w_dec && (i_wb_idx == IDX_W'(gi));
      assign w_cnt_next[gi] =
        i_flush                               ? '0 :
        (w_inc_hit[gi] && w_dec_hit[gi])      ? r_cnt[gi] :
        w_inc_hit[gi]                         ? r_cnt[gi] + 1'b1 :
        (w_dec_hit[gi] && r_cnt[gi] != '0)    ? r_cnt[gi] - 1'b1 :
                                                r_cnt[gi];
    end
  endgenerate

  // A writeback with nothing pending is a scoreboard bookkeeping error, flush or not.
  assign w_err = w_dec && (w_cnt_wb == '0) && !(w_inc && (i_issue_rd == i_wb_idx));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_err) r_sb_err <= 1'b1;
    end
  end

  // The last outstanding write landing this cycle is bypassed, so it is not busy.
  assign o_busy0 = (i_rd_idx0 != '0) && (w_cnt_rd0 != '0) &&
                   !(w_dec && (i_wb_idx == i_rd_idx0) && (w_cnt_rd0 == CNT_W'(1)));
  assign o_busy1 = (i_rd_idx1 != '0) && (w_cnt_rd1 != '0) &&
                   !(w_dec && (i_wb_idx == i_rd_idx1) && (w_cnt_rd1 == CNT_W'(1)));

  assign o_issue_ready = !(i_issue_we && (i_issue_rd != '0) && (w_cnt_iss == CNT_MAX) &&
                           !(w_dec && (i_wb_idx == i_issue_rd)));

  assign o_sb_err = r_sb_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, scoreboard counting,
// saturation, flush and sticky error behaviour.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  wb_idx;
  logic        wb_we;
  logic [31:0] wb_data;
  logic [4:0]  rd_idx0, rd_idx1;
  logic [31:0] rd_data0, rd_data1;
  logic        busy0, busy1;
  logic        issue_valid, issue_we;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        flush;
  logic        sb_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_idx(wb_idx), .i_wb_we(wb_we), .i_wb_data(wb_data),
    .i_rd_idx0(rd_idx0), .o_rd_data0(rd_data0),
    .i_rd_idx1(rd_idx1), .o_rd_data1(rd_data1),
    .o_busy0(busy0), .o_busy1(busy1),
    .i_issue_valid(issue_valid), .i_issue_we(issue_we), .i_issue_rd(issue_rd),
    .o_issue_ready(issue_ready), .i_flush(flush), .o_sb_err(sb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-24s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance past the next rising edge, then let new inputs settle before checks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 0; wb_idx = 0; wb_data = 0;
    issue_valid = 0; issue_we = 0; issue_rd = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_we = 1; issue_rd = rd;
    step();
    issue_valid = 0; issue_we = 0; issue_rd = 0;
  endtask

  initial begin
    rst_n = 0; rd_idx0 = 0; rd_idx1 = 0;
    idle();
    step(); step();
    rst_n = 1;

    // Post-reset: every register reads zero and nothing is busy.
    for (int i = 0; i < 32; i++) begin
      rd_idx0 = 5'(i); rd_idx1 = 5'(31 - i);
      #1;
      chk($sformatf("rst_rd0_r%0d", i), rd_data0, 32'h0);
      chk($sformatf("rst_rd1_r%0d", 31 - i), rd_data1, 32'h0);
      chk($sformatf("rst_busy0_r%0d", i), busy0, 0);
      chk($sformatf("rst_busy1_r%0d", 31 - i), busy1, 0);
    end
    issue_we = 1; issue_rd = 3; #1;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_sb_err", sb_err, 0);
    issue_we = 0; issue_rd = 0;

    // Bypass: one pending write to r5, then the writeback is forwarded same cycle.
    rd_idx0 = 5; rd_idx1 = 5;
    issue(5);
    #1;
    chk("r5_busy_pending", busy0, 1);
    wb_we = 1; wb_idx = 5; wb_data = 32'hDEADBEEF; #1;
    chk("r5_bypass_rd0", rd_data0, 32'hDEADBEEF);
    chk("r5_bypass_rd1", rd_data1, 32'hDEADBEEF);
    chk("r5_busy_drop", busy0, 0);
    step();
    idle(); #1;
    chk("r5_array_rd0", rd_data0, 32'hDEADBEEF);
    chk("r5_busy_after", busy0, 0);

    // Writes to r0 are dropped.
    rd_idx0 = 0;
    wb_we = 1; wb_idx = 0; wb_data = 32'h1234; #1;
    chk("r0_bypass_zero", rd_data0, 32'h0);
    step();
    idle(); #1;
    chk("r0_array_zero", rd_data0, 32'h0);
    chk("r0_no_sb_err", sb_err, 0);

    // Two in-flight writes to r7.
    rd_idx0 = 7;
    issue(7);
    issue(7);
    #1;
    chk("r7_busy_2pend", busy0, 1);
    wb_we = 1; wb_idx = 7; wb_data = 32'h11111111; #1;
    chk("r7_busy_first_wb", busy0, 1);
    step();
    wb_data = 32'h22222222; #1;
    chk("r7_busy_second_wb", busy0, 0);
    chk("r7_rd_second_wb", rd_data0, 32'h22222222);
    step();
    idle(); #1;
    chk("r7_busy_after", busy0, 0);
    chk("r7_rd_after", rd_data0, 32'h22222222);

    // Saturate r3 at 7 in-flight writes.
    rd_idx0 = 3; rd_idx1 = 3;
    for (int i = 0; i < 7; i++) begin
      issue_valid = 1; issue_we = 1; issue_rd = 3; #1;
      chk($sformatf("r3_ready_issue%0d", i), issue_ready, 1);
      step();
    end
    issue_valid = 1; issue_we = 1; issue_rd = 3; #1;
    chk("r3_ready_full", issue_ready, 0);
    chk("r3_busy1_full", busy1, 1);
    step();
    // Issue plus writeback at the max count: allowed, count unchanged.
    wb_we = 1; wb_idx = 3; wb_data = 32'h33; #1;
    chk("r3_ready_with_wb", issue_ready, 1);
    step();
    wb_we = 0; wb_idx = 0; issue_valid = 0; #1;
    chk("r3_ready_still_full", issue_ready, 0);
    issue_we = 0; issue_rd = 0;
    for (int i = 0; i < 7; i++) begin
      wb_we = 1; wb_idx = 3; wb_data = 32'h300 + 32'(i); #1;
      chk($sformatf("r3_busy_wb%0d", i), busy0, (i == 6) ? 1'b0 : 1'b1);
      step();
    end
    idle(); #1;
    chk("r3_busy_drained", busy0, 0);
    chk("r3_rd_last", rd_data0, 32'h306);
    chk("r3_no_sb_err", sb_err, 0);

    // Flush with a simultaneous issue and writeback.
    rd_idx0 = 9; rd_idx1 = 10;
    issue(9);
    issue(10);
    #1;
    chk("fl_busy9_pre", busy0, 1);
    chk("fl_busy10_pre", busy1, 1);
    flush = 1; issue_valid = 1; issue_we = 1; issue_rd = 11;
    wb_we = 1; wb_idx = 9; wb_data = 32'h55; #1;
    chk("fl_busy10_in_flush", busy1, 1);
    step();
    idle(); #1;
    chk("fl_busy9_post", busy0, 0);
    chk("fl_busy10_post", busy1, 0);
    chk("fl_rd9", rd_data0, 32'h55);
    rd_idx1 = 11; #1;
    chk("fl_busy11_post", busy1, 0);
    chk("fl_no_sb_err", sb_err, 0);

    // Writeback with nothing pending sets the sticky error.
    wb_we = 1; wb_idx = 12; wb_data = 32'hC; #1;
    chk("err_not_yet", sb_err, 0);
    step();
    idle(); #1;
    chk("err_set", sb_err, 1);
    step(); step(); step();
    chk("err_sticky", sb_err, 1);

    // Mid-operation reset with r4 holding data and two writes pending.
    rd_idx0 = 4;
    issue(4); issue(4); issue(4);
    wb_we = 1; wb_idx = 4; wb_data = 32'h44;
    step();
    idle(); #1;
    chk("r4_rd_pre_rst", rd_data0, 32'h44);
    chk("r4_busy_pre_rst", busy0, 1);
    rst_n = 0;
    step();
    rst_n = 1; #1;
    chk("r4_rd_post_rst", rd_data0, 32'h0);
    chk("r4_busy_post_rst", busy0, 0);
    chk("err_cleared_rst", sb_err, 0);
    issue_we = 1; issue_rd = 4; #1;
    chk("r4_ready_post_rst", issue_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
